// File: rtl/pkt_host_link.sv
// Host-side endpoint of the board UART packet protocol (0xFF, CMD, LEN, data).
// The TX path frames host commands for uart_tx; the RX path parses KEY/SW event frames from uart_rx.
module pkt_host_link #(
  parameter int TIMEOUT = 50000,
  parameter int TOW     = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        REQ_VALID,
  output logic        REQ_READY,
  input  logic [7:0]  REQ_CMD,
  input  logic [1:0]  REQ_LEN_M1,
  input  logic [31:0] REQ_DATA,
  output logic [7:0]  TX_DATA,
  output logic        TX_START,
  input  logic        TX_BUSY,
  input  logic [7:0]  RX_DATA,
  input  logic        RX_RECV,
  output logic [4:0]  KEY_STATE,
  output logic [17:0] SW_STATE,
  output logic        KEY_EVT,
  output logic        SW_EVT,
  output logic        RX_ERR
);

  typedef enum logic [1:0] {T_IDLE, T_LOAD, T_WAITHI, T_WAITLO} txState_e;
  typedef enum logic [1:0] {R_SYNC, R_CMD, R_LEN, R_DATA} rxState_e;

  txState_e    txState_q, txState_d;
  logic        alive_q;
  logic [7:0]  txCmd_q, txCmd_d;
  logic [2:0]  txLen_q, txLen_d;
  logic [31:0] txPayload_q, txPayload_d;
  logic [2:0]  txIdx_q, txIdx_d;
  logic [7:0]  txData_q, txData_d;
  logic        txStart_q, txStart_d;
  logic [1:0]  txShift;
  logic [7:0]  txByte;

  rxState_e    rxState_q, rxState_d;
  logic [7:0]  rxCmd_q, rxCmd_d;
  logic [7:0]  rxLen_q, rxLen_d;
  logic [17:0] rxAsm_q, rxAsm_d;
  logic [7:0]  rxCnt_q, rxCnt_d;
  logic [TOW-1:0] rxTmo_q, rxTmo_d;
  logic        rxDispatch_q, rxDispatch_d;
  logic [4:0]  keyState_q, keyState_d;
  logic [17:0] swState_q, swState_d;
  logic        keyEvt_q, keyEvt_d;
  logic        swEvt_q, swEvt_d;
  logic        rxErr_q, rxErr_d;

  // REQ_READY stays low while reset is held and only rises after the first clean edge.
  assign REQ_READY = alive_q && (txState_q == T_IDLE);
  assign TX_DATA   = txData_q;
  assign TX_START  = txStart_q;
  assign KEY_STATE = keyState_q;
  assign SW_STATE  = swState_q;
  assign KEY_EVT   = keyEvt_q;
  assign SW_EVT    = swEvt_q;
  assign RX_ERR    = rxErr_q;

  // Payload goes out most-significant used byte first.
  always_comb begin
    txShift = 2'(txLen_q + 3'd2 - txIdx_q);
    txByte  = 8'hFF;
    case (txIdx_q)
      3'd0: txByte = 8'hFF;
      3'd1: txByte = txCmd_q;
      3'd2: txByte = {5'd0, txLen_q};
      default: begin
        case (txShift)
          2'd0: txByte = txPayload_q[7:0];
          2'd1: txByte = txPayload_q[15:8];
          2'd2: txByte = txPayload_q[23:16];
          default: txByte = txPayload_q[31:24];
        endcase
      end
    endcase
  end

  always_comb begin
    txState_d   = txState_q;
    txCmd_d     = txCmd_q;
    txLen_d     = txLen_q;
    txPayload_d = txPayload_q;
    txIdx_d     = txIdx_q;
    txData_d    = txData_q;
    txStart_d   = 1'b0;
    case (txState_q)
      T_IDLE: begin
        if (REQ_VALID && REQ_READY) begin
          txCmd_d     = REQ_CMD;
          txLen_d     = {1'b0, REQ_LEN_M1} + 3'd1;
          txPayload_d = REQ_DATA;
          txIdx_d     = 3'd0;
          txState_d   = T_LOAD;
        end
      end
      T_LOAD: begin
        if (!TX_BUSY) begin
          txData_d  = txByte;
          txStart_d = 1'b1;
          txState_d = T_WAITHI;
        end
      end
      T_WAITHI: begin
        if (TX_BUSY) txState_d = T_WAITLO;
      end
      T_WAITLO: begin
        if (!TX_BUSY) begin
          if (txIdx_q == txLen_q + 3'd2) begin
            txState_d = T_IDLE;
          end else begin
            txIdx_d   = txIdx_q + 3'd1;
            txState_d = T_LOAD;
          end
        end
      end
      default: txState_d = T_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      txState_q   <= T_IDLE;
      alive_q     <= 1'b0;
      txCmd_q     <= 8'd0;
      txLen_q     <= 3'd0;
      txPayload_q <= 32'd0;
      txIdx_q     <= 3'd0;
      txData_q    <= 8'd0;
      txStart_q   <= 1'b0;
    end else begin
      txState_q   <= txState_d;
      alive_q     <= 1'b1;
      txCmd_q     <= txCmd_d;
      txLen_q     <= txLen_d;
      txPayload_q <= txPayload_d;
      txIdx_q     <= txIdx_d;
      txData_q    <= txData_d;
      txStart_q   <= txStart_d;
    end
  end

  // Only the 18 assembly bits that can ever reach KEY_STATE/SW_STATE are kept.
  always_comb begin
    rxState_d    = rxState_q;
    rxCmd_d      = rxCmd_q;
    rxLen_d      = rxLen_q;
    rxAsm_d      = rxAsm_q;
    rxCnt_d      = rxCnt_q;
    rxTmo_d      = rxTmo_q;
    rxDispatch_d = 1'b0;
    keyState_d   = keyState_q;
    swState_d    = swState_q;
    keyEvt_d     = 1'b0;
    swEvt_d      = 1'b0;
    rxErr_d      = 1'b0;

    if (rxState_q == R_SYNC) begin
      rxTmo_d = '0;
    end else if (RX_RECV) begin
      rxTmo_d = '0;
    end else if (rxTmo_q == TOW'(TIMEOUT - 1)) begin
      rxTmo_d   = '0;
      rxErr_d   = 1'b1;
      rxState_d = R_SYNC;
    end else begin
      rxTmo_d = rxTmo_q + TOW'(1);
    end

    if (RX_RECV) begin
      case (rxState_q)
        R_SYNC: begin
          if (RX_DATA == 8'hFF) rxState_d = R_CMD;
        end
        R_CMD: begin
          rxCmd_d   = RX_DATA;
          rxState_d = R_LEN;
        end
        R_LEN: begin
          rxLen_d = RX_DATA;
          rxAsm_d = '0;
          rxCnt_d = 8'd0;
          if (RX_DATA == 8'd0) begin
            rxErr_d   = 1'b1;
            rxState_d = R_SYNC;
          end else begin
            rxState_d = R_DATA;
          end
        end
        R_DATA: begin
          case (rxCnt_q)
            8'd0: rxAsm_d[7:0]   = RX_DATA;
            8'd1: rxAsm_d[15:8]  = RX_DATA;
            8'd2: rxAsm_d[17:16] = RX_DATA[1:0];
            default: ;
          endcase
          rxCnt_d = rxCnt_q + 8'd1;
          if (rxCnt_q + 8'd1 == rxLen_q) begin
            rxDispatch_d = 1'b1;
            rxState_d    = R_SYNC;
          end
        end
        default: rxState_d = R_SYNC;
      endcase
    end

    // Dispatch runs one cycle after the last data byte, while the parser already sits in R_SYNC.
    if (rxDispatch_q) begin
      if (rxLen_q > 8'd4) begin
        rxErr_d = 1'b1;
      end else if (rxCmd_q == 8'd0) begin
        if (rxLen_q == 8'd1) begin
          keyState_d = rxAsm_q[4:0];
          keyEvt_d   = 1'b1;
        end else begin
          rxErr_d = 1'b1;
        end
      end else if (rxCmd_q == 8'd1) begin
        if (rxLen_q == 8'd3) begin
          swState_d = rxAsm_q;
          swEvt_d   = 1'b1;
        end else begin
          rxErr_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rxState_q    <= R_SYNC;
      rxCmd_q      <= 8'd0;
      rxLen_q      <= 8'd0;
      rxAsm_q      <= '0;
      rxCnt_q      <= 8'd0;
      rxTmo_q      <= '0;
      rxDispatch_q <= 1'b0;
      keyState_q   <= 5'd0;
      swState_q    <= 18'd0;
      keyEvt_q     <= 1'b0;
      swEvt_q      <= 1'b0;
      rxErr_q      <= 1'b0;
    end else begin
      rxState_q    <= rxState_d;
      rxCmd_q      <= rxCmd_d;
      rxLen_q      <= rxLen_d;
      rxAsm_q      <= rxAsm_d;
      rxCnt_q      <= rxCnt_d;
      rxTmo_q      <= rxTmo_d;
      rxDispatch_q <= rxDispatch_d;
      keyState_q   <= keyState_d;
      swState_q    <= swState_d;
      keyEvt_q     <= keyEvt_d;
      swEvt_q      <= swEvt_d;
      rxErr_q      <= rxErr_d;
    end
  end

endmodule

// File: doc/pkt_host_link.md
Name: pkt_host_link

Overview:
- Host-side endpoint of the board's UART packet protocol. Each frame is 0xFF, then CMD, then LEN, then LEN data bytes.
- The TX path builds and sends command frames to the board: LEDG = 2, LEDR = 3, SET_HEX = 4.
- The RX path parses event frames from the board, KEY = 0 and SW = 1, and holds the latest KEY/SW state.
- The block sits between a host controller and the existing uart_tx/uart_rx byte-level cores.

Parameters:
- TIMEOUT, 50000: RX inter-byte timeout in CLK cycles, measured while a frame is partially received.
- TOW, 16: width of the timeout counter; must satisfy 2^TOW > TIMEOUT.

Ports:
- CLK  in  1  system clock; all logic on its rising edge.
- RST  in  1  asynchronous, active-high reset.
- REQ_VALID  in  1  command request valid.
- REQ_READY  out  1  block can accept a request.
- REQ_CMD  in  8  command byte.
- REQ_LEN_M1  in  2  data length minus 1; lengths 1..4.
- REQ_DATA  in  32  payload; bytes [8*len-1:0] are used.
- TX_DATA  out  8  byte to uart_tx.
- TX_START  out  1  one-cycle start strobe to uart_tx.
- TX_BUSY  in  1  uart_tx busy.
- RX_DATA  in  8  byte from uart_rx.
- RX_RECV  in  1  one-cycle byte-valid strobe from uart_rx.
- KEY_STATE  out  5  last received pressed-key mask.
- SW_STATE  out  18  last received switch state.
- KEY_EVT  out  1  one-cycle pulse when KEY_STATE is updated.
- SW_EVT  out  1  one-cycle pulse when SW_STATE is updated.
- RX_ERR  out  1  one-cycle pulse on a malformed or timed-out frame.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-frame): every output is 0 except REQ_READY, which is 1 after the first CLK edge with RST low. TX and RX FSMs return to their idle states, the timeout counter clears, and any partially sent or received frame is abandoned.
- The TX and RX paths are fully independent and may run concurrently.

TX FSM: T_IDLE, T_LOAD, T_WAITHI, T_WAITLO.
- T_IDLE:
  - REQ_READY = 1.
  - On REQ_VALID & REQ_READY, latch CMD, N = REQ_LEN_M1 + 1, and DATA; set byte index i = 0; go to T_LOAD.
  - REQ_READY is 0 in all other states.
- Byte sequence:
  - i = 0: 0xFF.
  - i = 1: CMD.
  - i = 2: N.
  - i = 3 .. N+2: data bytes, most-significant used byte first, i.e. DATA[8N-1:8N-8] down to DATA[7:0]. The board shifts data in MSB-first.
  - Example: SET_HEX with N = 2 and DATA = 0x0340 sends 03, then 40.
- T_LOAD:
  - When TX_BUSY = 0, drive TX_DATA = byte[i] and pulse TX_START for exactly one cycle; go to T_WAITHI.
  - TX_DATA holds its value until the next T_LOAD.
- T_WAITHI: wait for TX_BUSY = 1, then go to T_WAITLO.
- T_WAITLO: wait for TX_BUSY = 0.
  - If i = N+2, go to T_IDLE.
  - Otherwise i++ and go to T_LOAD.
- A frame of length N produces exactly N+3 TX_START pulses. There is no byte escaping: 0xFF inside the payload is sent raw.

RX FSM: R_SYNC, R_CMD, R_LEN, R_DATA. The FSM advances only on RX_RECV.
- R_SYNC:
  - Byte 0xFF goes to R_CMD.
  - Any other byte is discarded silently (no RX_ERR).
- R_CMD: latch the cmd; go to R_LEN.
- R_LEN:
  - Latch len. Clear the assembly register and byte count c.
  - len = 0: RX_ERR, go to R_SYNC.
  - Otherwise go to R_DATA.
- R_DATA:
  - Bytes arrive LSB-first: byte c goes into asm[8c+7:8c] if c < 4; bytes with c >= 4 are dropped. c increments.
  - When c reaches len, dispatch the frame and go to R_SYNC.
  - A 0xFF byte received in R_DATA is treated as data.
- Dispatch, in the cycle after the last byte is registered:
  - cmd 0, len = 1: KEY_STATE <= asm[4:0] (the board sends the inverted KEY, so 1 = pressed); KEY_EVT pulses.
  - cmd 1, len = 3: SW_STATE <= asm[17:0]; SW_EVT pulses.
  - cmd 0 or 1 with any other len, or any len > 4: RX_ERR pulses; state unchanged.
  - Any other cmd: ignored, no error.
- Timeout:
  - The counter runs while the FSM is in R_CMD, R_LEN or R_DATA and clears on every RX_RECV.
  - When it reaches TIMEOUT, pulse RX_ERR and go to R_SYNC.
  - If RX_RECV arrives in the same cycle the counter reaches TIMEOUT, the byte wins and no timeout occurs.
- Same-cycle events: KEY_EVT, SW_EVT and RX_ERR are mutually exclusive by construction. A new RX_RECV in the dispatch cycle is processed normally in R_SYNC.

Test Plan:
- Reset, then REQ LEDG with len 1, DATA 0xA5 → TX bytes FF 02 01 A5; 4 TX_START pulses; REQ_READY returns to 1 after the last TX_BUSY fall.
- REQ SET_HEX with len 2, DATA 0x0540, and a TX_BUSY model holding busy for 10 cycles → bytes FF 04 02 05 40; REQ_READY stays 0 throughout; a second REQ_VALID during the frame is not accepted.
- RX bytes 12 FF 01 03 55 AA 02 → SW_STATE = 0x2AA55, one SW_EVT pulse, no RX_ERR.
- RX bytes FF 00 01 FF → KEY_STATE = 0x1F, KEY_EVT pulses. Then FF 00 02 01 02 → RX_ERR pulses and KEY_STATE is unchanged.
- RX bytes FF 01, then no bytes for TIMEOUT cycles → RX_ERR after exactly TIMEOUT cycles. Then FF 00 01 04 → KEY_STATE = 0x04.
- Assert RST in the middle of both a TX frame (after byte 2) and an RX frame → TX_START = 0 and all outputs clear immediately; after release, the next request is sent as a complete frame starting with FF.
